// File: rtl/lfsr_pkg.sv
// Shared types and constants for the Galois LFSR word generator.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_STIR  = 2'd2
  } lfsr_st_e;

  // Known maximal-length feedback masks for common widths.
  localparam logic [7:0]  TAPS_8  = 8'h1D;
  localparam logic [15:0] TAPS_16 = 16'h6801;
  localparam logic [31:0] TAPS_32 = 32'h0040_0007;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR shift: MSB feeds back into every bit selected by TAPS.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  always_comb begin
    next_o = {state_i[WIDTH-2:0], 1'b0} ^ (state_i[WIDTH-1] ? TAPS : '0);
  end

endmodule

// File: rtl/lfsr_gen.sv
// Pseudo-random word source: Galois LFSR with seed load, lock-up guard,
// period-wrap pulse, inter-word stride and a valid/ready output.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] TAPS           = 8'h1D,
  parameter logic [WIDTH-1:0] SEED           = 8'h01,
  parameter int               STEPS_PER_WORD = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             seed_load_in,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rand_ready_in,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid_out,
  output logic             lockup_out,
  output logic             wrap_out
);

  localparam logic [7:0] STIR_LOAD =
    (STEPS_PER_WORD > 1) ? 8'(STEPS_PER_WORD - 2) : 8'd0;

  lfsr_st_e         st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] state_nxt;
  logic             accept, shift;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .state_i (state_q),
    .next_o  (state_nxt)
  );

  assign accept = (st_q == ST_VALID) & rand_ready_in & en_in;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    seed_d   = seed_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    shift    = 1'b0;

    if (!en_in) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        ST_IDLE: st_d = ST_VALID;
        ST_VALID: begin
          if (accept) begin
            shift = 1'b1;
            if (STEPS_PER_WORD > 1) begin
              cnt_d = STIR_LOAD;
              st_d  = ST_STIR;
            end
          end
        end
        ST_STIR: begin
          shift = 1'b1;
          if (cnt_q == '0) st_d  = ST_VALID;
          else             cnt_d = cnt_q - 8'd1;
        end
        default: st_d = ST_IDLE;
      endcase
    end

    // An all-zero state would stick forever; substitute SEED instead of shifting.
    if (state_q == '0) begin
      state_d  = SEED;
      lockup_d = 1'b1;
    end else if (shift) begin
      state_d = state_nxt;
      wrap_d  = (state_nxt == seed_q);
    end

    // Seed load overrides everything, including a coincident handshake.
    if (seed_load_in) begin
      wrap_d = 1'b0;
      if (seed_in == '0) begin
        state_d  = SEED;
        seed_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = seed_in;
        seed_d   = seed_in;
        lockup_d = 1'b0;
      end
      st_d  = en_in ? ST_VALID : ST_IDLE;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      state_q  <= SEED;
      seed_q   <= SEED;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign rand_out       = state_q;
  assign rand_valid_out = (st_q == ST_VALID);
  assign lockup_out     = lockup_q;
  assign wrap_out       = wrap_q;

endmodule
